// File: rtl/detect_sequence_param_shift_reg.sv
// Serial-bit sequence detector with a programmable pattern and length,
// optional overlapping matches and a saturating match counter.
module detect_sequence_param_shift_reg #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_bit,
    input  logic               bit_valid,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pattern_len,
    input  logic               overlap,
    input  logic               clear,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               saturated
);

    localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_inc;
    logic               len_ok;
    logic               fill_ok;
    logic               match;

    always_comb begin
        window = {hist[MAX_LEN-2:0], new_bit};
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(pattern_len));
        end
        len_ok = (pattern_len != '0) && (pattern_len <= FULL);
        // fill counts bits before this edge; the incoming bit makes fill+1
        fill_ok = (({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, pattern_len});
        fill_inc = (fill == FULL) ? fill : fill + LEN_W'(1);
        match = len_ok && fill_ok && (((window ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist        <= '0;
            fill        <= '0;
            detected    <= 1'b0;
            match_count <= '0;
            saturated   <= 1'b0;
        end else if (clear) begin
            hist        <= '0;
            fill        <= '0;
            detected    <= 1'b0;
            match_count <= '0;
            saturated   <= 1'b0;
        end else begin
            detected <= 1'b0;
            if (bit_valid) begin
                hist <= window;
                fill <= fill_inc;
                if (match) begin
                    detected <= 1'b1;
                    // non-overlapping mode restarts the window count
                    if (!overlap) begin
                        fill <= '0;
                    end
                    if (match_count != CNT_MAX) begin
                        match_count <= match_count + CNT_W'(1);
                    end else begin
                        saturated <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
